// File: rtl/interp_pkg.sv
// Shared helpers for the interpolating sample buffer: depth derivation,
// default widths and the fixed-point linear-blend arithmetic.
package interp_pkg;

  // Default per-channel slice width and position layout
  localparam int unsigned DEF_CH     = 2;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_FRAC_W = 8;

  // Wide signed carrier for the blend math; any DATA_W+FRAC_W+2 <= 64 fits
  localparam int unsigned LERP_W = 64;
  typedef logic signed [LERP_W-1:0] lerp_t;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // p = (b - a) * frac, frac treated as non-negative
  function automatic lerp_t lerp_prod(input lerp_t a, input lerp_t b, input lerp_t frac);
    return (b - a) * frac;
  endfunction

  // y = a + round-half-up(p / 2**frac_w); caller truncates to DATA_W
  function automatic lerp_t lerp_round(input lerp_t a, input lerp_t p, input int unsigned frac_w);
    lerp_t half;
    half = lerp_t'(1) <<< (frac_w - 1);
    return a + ((p + half) >>> frac_w);
  endfunction

endpackage

// File: rtl/interp_lerp_ram_if.sv
// Bus bundle for interp_lerp_ram.
//   wr_data/wr_en         : sample write stream
//   wr_ptr/fill           : next write address, valid-sample count
//   rd_req/rd_pos         : interpolated read request {idx, frac}
//   rd_valid/rd_data/rd_err : read result
// master = producer/consumer side, slave = buffer side.
interface interp_lerp_ram_if #(
  parameter int unsigned CH     = 2,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned FRAC_W = 8
);
  logic [CH*DATA_W-1:0]     wr_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_ptr;
  logic [ADDR_W:0]          fill;
  logic                     rd_req;
  logic [ADDR_W+FRAC_W-1:0] rd_pos;
  logic                     rd_valid;
  logic [CH*DATA_W-1:0]     rd_data;
  logic                     rd_err;

  modport master (
    output wr_data, wr_en, rd_req, rd_pos,
    input  wr_ptr, fill, rd_valid, rd_data, rd_err
  );

  modport slave (
    input  wr_data, wr_en, rd_req, rd_pos,
    output wr_ptr, fill, rd_valid, rd_data, rd_err
  );
endinterface

// File: rtl/interp_sdpram.sv
// Single-clock simple dual-port RAM, read-first, 1-cycle registered read.
//   clk     : clock
//   we_i    : write enable, waddr_i/wdata_i : write port
//   raddr_i : read address, rdata_o : data one cycle later
module interp_sdpram
  import interp_pkg::*;
#(
  parameter int unsigned AW = DEF_ADDR_W,
  parameter int unsigned DW = DEF_CH * DEF_DATA_W
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  localparam int unsigned DEPTH = depth_of(AW);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Non-blocking read of the same address returns the pre-write word
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/interp_lerp_ram.sv
// Multi-channel circular sample buffer with linear-interpolating reads.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of interp_lerp_ram_if (write stream, fill status,
//              {idx, frac} read request, interpolated result + error flag)
// Read latency is 3 cycles, 4 with OUTPUT_REG = 1; one request per cycle.
module interp_lerp_ram
  import interp_pkg::*;
#(
  parameter int unsigned CH         = DEF_CH,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned FRAC_W     = DEF_FRAC_W,
  parameter int unsigned OUTPUT_REG = 0
) (
  input logic              clk,
  input logic              rst,
  interp_lerp_ram_if.slave bus
);
  localparam int unsigned DEPTH = depth_of(ADDR_W);
  localparam int unsigned ROW_W = CH * DATA_W;
  localparam int unsigned P_W   = DATA_W + FRAC_W + 2;
  localparam int unsigned CNT_W = ADDR_W + 1;

  // Write pointer and saturating fill counter
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic              full_c;

  assign full_c = (fill_q == CNT_W'(DEPTH));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (bus.wr_en) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (!full_c) fill_d = fill_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
    end
  end

  assign bus.wr_ptr = wr_ptr_q;
  assign bus.fill   = fill_q;

  // Request decode; error check uses the pre-write fill
  logic [ADDR_W-1:0] idx_c, nidx_c;
  logic [FRAC_W-1:0] frac_c;
  logic              err_c;

  assign idx_c  = bus.rd_pos[FRAC_W +: ADDR_W];
  assign frac_c = bus.rd_pos[FRAC_W-1:0];
  assign nidx_c = idx_c + ADDR_W'(1);
  assign err_c  = !full_c && ((CNT_W'(idx_c) >= fill_q) ||
                              ((frac_c != '0) && (CNT_W'(nidx_c) >= fill_q)));

  // Two mirrored copies so idx and idx+1 are fetched in the same cycle
  logic [ROW_W-1:0] a_row, b_row;

  interp_sdpram #(.AW(ADDR_W), .DW(ROW_W)) u_ram_a (
    .clk(clk), .we_i(bus.wr_en), .waddr_i(wr_ptr_q), .wdata_i(bus.wr_data),
    .raddr_i(idx_c), .rdata_o(a_row)
  );

  interp_sdpram #(.AW(ADDR_W), .DW(ROW_W)) u_ram_b (
    .clk(clk), .we_i(bus.wr_en), .waddr_i(wr_ptr_q), .wdata_i(bus.wr_data),
    .raddr_i(nidx_c), .rdata_o(b_row)
  );

  // Control pipeline: S0 accept, S1 RAM out, S2 product, S3 result
  logic              v0_q, v1_q, v2_q;
  logic              err0_q, err1_q, err2_q;
  logic [FRAC_W-1:0] frac0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      err2_q  <= 1'b0;
      frac0_q <= '0;
    end else begin
      v0_q    <= bus.rd_req;
      err0_q  <= err_c;
      frac0_q <= frac_c;
      v1_q    <= v0_q;
      err1_q  <= err0_q;
      v2_q    <= v1_q;
      err2_q  <= err1_q;
    end
  end

  // Per-channel blend datapath
  wire [ROW_W-1:0] y_row;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic signed [DATA_W-1:0] a_c, b_c, a1_q, y2_q;
    logic signed [P_W-1:0]    p1_q;

    assign a_c = a_row[c*DATA_W +: DATA_W];
    assign b_c = b_row[c*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
      if (rst) begin
        a1_q <= '0;
        p1_q <= '0;
        y2_q <= '0;
      end else begin
        a1_q <= a_c;
        p1_q <= P_W'(lerp_prod(lerp_t'(a_c), lerp_t'(b_c), lerp_t'(frac0_q)));
        y2_q <= DATA_W'(lerp_round(lerp_t'(a1_q), lerp_t'(p1_q), FRAC_W));
      end
    end

    assign y_row[c*DATA_W +: DATA_W] = y2_q;
  end

  // Optional extra output stage
  if (OUTPUT_REG != 0) begin : g_oreg
    logic             v3_q, err3_q;
    logic [ROW_W-1:0] y3_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        v3_q   <= 1'b0;
        err3_q <= 1'b0;
        y3_q   <= '0;
      end else begin
        v3_q   <= v2_q;
        err3_q <= err2_q;
        y3_q   <= y_row;
      end
    end

    assign bus.rd_valid = v3_q;
    assign bus.rd_err   = err3_q;
    assign bus.rd_data  = y3_q;
  end else begin : g_nooreg
    assign bus.rd_valid = v2_q;
    assign bus.rd_err   = err2_q;
    assign bus.rd_data  = y_row;
  end
endmodule
